// File: rtl/membus_arbiter_if.sv
// Bundle of the fetch, data and unified memory buses around membus_arbiter.
// master = the arbiter; slave = the requesters and memory that surround it.
interface membus_arbiter_if;
  logic [63:0] imem_addr;
  logic        imem_addr_valid;
  logic [63:0] imem_data;
  logic        imem_data_valid;

  logic [63:0] dmem_addr;
  logic [63:0] dmem_dout;
  logic [63:0] dmem_din;
  logic [1:0]  dmem_write_width;
  logic        dmem_rstrobe;
  logic        dmem_wstrobe;
  logic        dmem_cycle_complete;

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_we;
  logic        mem_req;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        mem_owner;

  modport master (
    input  imem_addr, imem_addr_valid,
    output imem_data, imem_data_valid,
    input  dmem_addr, dmem_dout, dmem_write_width, dmem_rstrobe, dmem_wstrobe,
    output dmem_din, dmem_cycle_complete,
    output mem_addr, mem_wdata, mem_width, mem_we, mem_req, mem_owner,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output imem_addr, imem_addr_valid,
    input  imem_data, imem_data_valid,
    output dmem_addr, dmem_dout, dmem_write_width, dmem_rstrobe, dmem_wstrobe,
    input  dmem_din, dmem_cycle_complete,
    input  mem_addr, mem_wdata, mem_width, mem_we, mem_req, mem_owner,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/membus_arbiter.sv
// Fetch/data arbiter onto one memory port, one transaction at a time.
// Define MEMBUS_ARB_FAIRNESS_EN to bound consecutive data grants while a fetch waits.
module membus_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input logic            clk,
  input logic            rst_n,
  membus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        we_q, we_d;
  logic        d_req;
  logic        d_win;

  if (DSTREAK_MAX < 1 || DSTREAK_MAX > 15) begin : g_bad_dstreak
    $error("membus_arbiter: DSTREAK_MAX must be in 1..15");
  end

  assign d_req = bus.dmem_rstrobe | bus.dmem_wstrobe;

`ifdef MEMBUS_ARB_FAIRNESS_EN
  logic [3:0] streak_q, streak_d;

  // Fetch wins only once the data port has used its full streak against a waiting fetch.
  assign d_win = d_req && !(bus.imem_addr_valid && (streak_q == 4'(DSTREAK_MAX)));

  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (d_win) begin
        streak_d = bus.imem_addr_valid ? streak_q + 4'd1 : '0;
      end else if (bus.imem_addr_valid) begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign d_win = d_req;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          addr_d  = bus.dmem_addr;
          wdata_d = bus.dmem_dout;
          width_d = bus.dmem_write_width;
          we_d    = bus.dmem_wstrobe;
          state_d = D_BUSY;
        end else if (bus.imem_addr_valid) begin
          addr_d  = bus.imem_addr;
          width_d = 2'd3;
          we_d    = 1'b0;
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      we_q    <= we_d;
    end
  end

  // Request and owner decode straight from the state register so reset drops them at once.
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_owner = (state_q == D_BUSY);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_width = width_q;
  assign bus.mem_we    = we_q;

  assign bus.imem_data           = bus.mem_rdata;
  assign bus.dmem_din            = bus.mem_rdata;
  assign bus.imem_data_valid     = (state_q == I_BUSY) && bus.mem_ack;
  assign bus.dmem_cycle_complete = (state_q == D_BUSY) && bus.mem_ack;

endmodule

// File: tb/tb_membus_arbiter.sv
// Scoreboard bench for membus_arbiter: stimulus queues expected transactions,
// a monitor checks each one at its completion pulse against the latched bus.
module tb_membus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  membus_arbiter_if bus ();

  membus_arbiter #(.DSTREAK_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        owner;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  width;
    logic        we;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int unsigned lat = 2;
  bit mem_en = 1'b1;
  bit stray  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    return (a == 64'h1000) ? 64'h0000_0000_DEAD_BEEF : ~a;
  endfunction

  // Memory responder: ack arrives 'lat' cycles after mem_req rises.
  initial begin
    int unsigned req_cnt;
    req_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      if (stray) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h0BAD;
      end else if (bus.mem_req && mem_en) begin
        if (req_cnt == lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_model(bus.mem_addr);
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.imem_data_valid || bus.dmem_cycle_complete) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got imem=%b dmem=%b expected none at %0t",
                   bus.imem_data_valid, bus.dmem_cycle_complete, $time);
        end else begin
          e = sb.pop_front();
          chk("owner", 64'(bus.mem_owner), 64'(e.owner));
          chk("dmem_pulse", 64'(bus.dmem_cycle_complete), 64'(e.owner));
          chk("imem_pulse", 64'(bus.imem_data_valid), 64'(!e.owner));
          chk("mem_req_at_ack", 64'(bus.mem_req), 64'd1);
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_width", 64'(bus.mem_width), 64'(e.width));
          chk("mem_we", 64'(bus.mem_we), 64'(e.we));
          if (e.owner) begin
            chk("mem_wdata", bus.mem_wdata, e.wdata);
            chk("dmem_din", bus.dmem_din, e.rdata);
          end else begin
            chk("imem_data", bus.imem_data, e.rdata);
          end
        end
      end
    end
  end

  task automatic push(input logic o, input logic [63:0] a, input logic [63:0] wd,
                      input logic [1:0] w, input logic we, input logic [63:0] rd);
    exp_t e;
    e.owner = o; e.addr = a; e.wdata = wd; e.width = w; e.we = we; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic drop_reqs();
    bus.imem_addr_valid = 1'b0;
    bus.dmem_rstrobe    = 1'b0;
    bus.dmem_wstrobe    = 1'b0;
  endtask

  // Counts completion pulses and withdraws all requests in the pulse cycle.
  task automatic wait_completions(input int unsigned n, input int unsigned budget, input string nm);
    int unsigned seen;
    seen = 0;
    for (int unsigned c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (bus.imem_data_valid || bus.dmem_cycle_complete) seen++;
    end
    drop_reqs();
    chk({"completions_", nm}, 64'(seen), 64'(n));
  endtask

  localparam logic [63:0] RD_2008 = 64'hFFFF_FFFF_FFFF_DFF7;
  localparam logic [63:0] RD_2010 = 64'hFFFF_FFFF_FFFF_DFEF;
  localparam logic [63:0] RD_3000 = 64'hFFFF_FFFF_FFFF_CFFF;
  localparam logic [63:0] RD_4000 = 64'hFFFF_FFFF_FFFF_BFFF;

  initial begin
    bus.imem_addr = '0;
    bus.imem_addr_valid = 1'b0;
    bus.dmem_addr = '0;
    bus.dmem_dout = '0;
    bus.dmem_write_width = '0;
    bus.dmem_rstrobe = 1'b0;
    bus.dmem_wstrobe = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_owner", 64'(bus.mem_owner), 64'd0);
    chk("rst_imem_valid", 64'(bus.imem_data_valid), 64'd0);
    chk("rst_dmem_complete", 64'(bus.dmem_cycle_complete), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst_mem_width", 64'(bus.mem_width), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch only, ack two cycles after mem_req rises
    lat = 2;
    push(1'b0, 64'h1000, 64'h0, 2'd3, 1'b0, 64'h0000_0000_DEAD_BEEF);
    bus.imem_addr = 64'h1000;
    bus.imem_addr_valid = 1'b1;
    chk("fetch_req_cycle_n", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    chk("fetch_req_cycle_n1", 64'(bus.mem_req), 64'd1);
    wait_completions(1, 20, "fetch");
    @(negedge clk);
    chk("fetch_idle_after_ack", 64'(bus.mem_req), 64'd0);

    // Store; requester inputs are scrambled while busy and must be ignored
    lat = 1;
    push(1'b1, 64'h2008, 64'h55, 2'd0, 1'b1, RD_2008);
    bus.dmem_addr = 64'h2008;
    bus.dmem_dout = 64'h55;
    bus.dmem_write_width = 2'd0;
    bus.dmem_wstrobe = 1'b1;
    @(negedge clk);
    bus.dmem_addr = 64'hDEAD_0000;
    bus.dmem_dout = 64'hFFFF;
    bus.dmem_write_width = 2'd2;
    wait_completions(1, 20, "store");
    @(negedge clk);

    // Simultaneous load and store strobes behave as a store
    push(1'b1, 64'h2010, 64'hA5, 2'd2, 1'b1, RD_2010);
    bus.dmem_addr = 64'h2010;
    bus.dmem_dout = 64'hA5;
    bus.dmem_write_width = 2'd2;
    bus.dmem_rstrobe = 1'b1;
    bus.dmem_wstrobe = 1'b1;
    wait_completions(1, 20, "rw_store");
    @(negedge clk);

    // Contention: fetch and loads requested continuously
    lat = 1;
    for (int i = 0; i < 10; i++) begin
`ifdef MEMBUS_ARB_FAIRNESS_EN
      if ((i % 5) == 4) push(1'b0, 64'h4000, 64'h0, 2'd3, 1'b0, RD_4000);
      else              push(1'b1, 64'h3000, 64'h77, 2'd3, 1'b0, RD_3000);
`else
      push(1'b1, 64'h3000, 64'h77, 2'd3, 1'b0, RD_3000);
`endif
    end
    bus.imem_addr = 64'h4000;
    bus.imem_addr_valid = 1'b1;
    bus.dmem_addr = 64'h3000;
    bus.dmem_dout = 64'h77;
    bus.dmem_write_width = 2'd3;
    bus.dmem_rstrobe = 1'b1;
    wait_completions(10, 200, "contention");
    @(negedge clk);
    chk("contention_queue_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Stray ack in IDLE
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_ack_seen", 64'(bus.mem_ack), 64'd1);
    chk("stray_imem_valid", 64'(bus.imem_data_valid), 64'd0);
    chk("stray_dmem_complete", 64'(bus.dmem_cycle_complete), 64'd0);
    @(negedge clk);
    chk("stray_no_req", 64'(bus.mem_req), 64'd0);

    // Reset during D_BUSY, then a late ack
    mem_en = 1'b0;
    bus.dmem_addr = 64'h2020;
    bus.dmem_dout = 64'h99;
    bus.dmem_wstrobe = 1'b1;
    @(negedge clk);
    chk("busy_before_reset", 64'(bus.mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", 64'(bus.mem_req), 64'd0);
    chk("async_reset_addr", bus.mem_addr, 64'd0);
    drop_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("late_ack_imem_valid", 64'(bus.imem_data_valid), 64'd0);
    chk("late_ack_dmem_complete", 64'(bus.dmem_cycle_complete), 64'd0);
    @(negedge clk);
    chk("late_ack_no_req", 64'(bus.mem_req), 64'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
